// File: rtl/dsm1_mod.sv
// dsm1_mod: first-order delta-sigma modulator core.
// Accepts 16-bit unsigned PCM samples over valid/ready. Each sample is held for OSR
// modulator ticks. Every tick the held sample is added into a 16-bit phase accumulator,
// and the carry out of that addition becomes the registered 1-bit output stream.
module dsm1_mod #(
  parameter int OSR = 64  // legal range 2..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        dout,
  output logic        underrun,
  input  logic        clr_underrun
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [15:0]     r_x;
  logic [15:0]     r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_dout;
  logic            r_underrun;

  logic            w_boundary;
  logic [16:0]     w_sum;

  // Last tick of the current window: the only RUN cycle that may take a new sample.
  assign w_boundary = (r_state == S_RUN) && (r_cnt == CNT_LAST);

  // 17-bit sum; bit 16 is the carry that forms the bitstream.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_x};

  // Ready is decoded from registered state only, never from din_valid.
  assign din_ready = (r_state == S_IDLE) || w_boundary;

  assign dout     = r_dout;
  assign underrun = r_underrun;

  // Sequencer, accumulator, carry capture and sticky underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= 16'h0000;
      r_acc      <= 16'h0000;
      r_cnt      <= '0;
      r_dout     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      // Clear is applied first so that a set on the same edge overrides it.
      if (clr_underrun) begin
        r_underrun <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          // Capture only; the first accumulate happens on the following edge.
          if (din_valid) begin
            r_x     <= din;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Accumulate with the currently held sample, even on the boundary edge.
          r_dout <= w_sum[16];
          r_acc  <= w_sum[15:0];
          if (w_boundary) begin
            r_cnt <= '0;
            if (din_valid) begin
              r_x <= din;
            end else begin
              // No sample available: repeat the old one and flag it.
              r_underrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsm1_mod.sv
// tb_dsm1_mod: scoreboard bench for dsm1_mod. The stimulus process runs a small
// behavioural model of the modulator and queues the expected outputs for each edge;
// a separate monitor pops and compares them on the falling clock edge. Hand-computed
// ones-per-window counts and reset values are checked directly.
module tb_dsm1_mod;

  localparam int OSR = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        din_valid = 1'b0;
  logic        clr_underrun = 1'b0;
  logic        din_ready;
  logic        dout;
  logic        underrun;

  dsm1_mod #(.OSR(OSR)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic r;
    logic u;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int ones  = 0;
  int rdys  = 0;

  // reference model state
  bit          m_run;
  logic [15:0] m_x;
  logic [15:0] m_acc;
  int          m_cnt;
  bit          m_dout;
  bit          m_ur;

  task automatic model_reset();
    m_run  = 1'b0;
    m_x    = 16'h0000;
    m_acc  = 16'h0000;
    m_cnt  = 0;
    m_dout = 1'b0;
    m_ur   = 1'b0;
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, expv, $time);
    end
  endtask

  // One modulator edge: drive inputs, advance the model, queue expectation.
  task automatic step(input logic [15:0] d, input logic v, input logic c);
    logic [16:0] s;
    exp_t e;
    din = d;
    din_valid = v;
    clr_underrun = c;
    if (c) m_ur = 1'b0;
    if (!m_run) begin
      if (v) begin
        m_x = d;
        m_cnt = 0;
        m_run = 1'b1;
      end
    end else begin
      s = {1'b0, m_acc} + {1'b0, m_x};
      m_dout = s[16];
      m_acc = s[15:0];
      if (m_cnt == OSR - 1) begin
        m_cnt = 0;
        if (v) m_x = d;
        else m_ur = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    e.d = m_dout;
    e.r = (!m_run) || (m_cnt == OSR - 1);
    e.u = m_ur;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    if (dout === 1'b1) ones++;
    if (din_ready === 1'b1) rdys++;
  endtask

  task automatic run(input int n, input logic [15:0] d, input logic v, input logic c);
    for (int i = 0; i < n; i++) step(d, v, c);
  endtask

  // Asynchronous reset away from the clock edge, checked before any edge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk({nm, "_dout"}, int'(dout), 0);
    chk({nm, "_ready"}, int'(din_ready), 1);
    chk({nm, "_underrun"}, int'(underrun), 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    din_valid = 1'b0;
    clr_underrun = 1'b0;
  endtask

  // Scoreboard monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({dout, din_ready, underrun} !== {e.d, e.r, e.u}) begin
        n_err++;
        $display("FAIL sb_tick: dout/din_ready/underrun got %b%b%b expected %b%b%b at %0t",
                 dout, din_ready, underrun, e.d, e.r, e.u, $time);
      end
    end
  end

  initial begin
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("por_dout", int'(dout), 0);
    chk("por_ready", int'(din_ready), 1);
    chk("por_underrun", int'(underrun), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // 0x8000 held valid: 0,1,0,1..., 32 ones and one ready pulse per window
    step(16'h8000, 1'b1, 1'b0);
    ones = 0; rdys = 0;
    run(64, 16'h8000, 1'b1, 1'b0);
    chk("w8000_ones_1", ones, 32);
    chk("w8000_ready_1", rdys, 1);
    ones = 0; rdys = 0;
    run(64, 16'h8000, 1'b1, 1'b0);
    chk("w8000_ones_2", ones, 32);
    chk("w8000_ready_2", rdys, 1);

    // switch to 0x4000 at a boundary, then to 0x0000
    run(64, 16'h4000, 1'b1, 1'b0);
    ones = 0;
    run(64, 16'h4000, 1'b1, 1'b0);
    chk("w4000_ones", ones, 16);
    run(63, 16'h4000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    ones = 0;
    run(64, 16'h0000, 1'b1, 1'b0);
    chk("w0000_ones", ones, 0);

    // underrun: load 0x4000, then miss one boundary
    run(63, 16'h0000, 1'b1, 1'b0);
    step(16'h4000, 1'b1, 1'b0);
    run(63, 16'h4000, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    chk("ur_set", int'(underrun), 1);
    ones = 0;
    run(63, 16'h0000, 1'b0, 1'b0);
    step(16'h2000, 1'b1, 1'b0);
    chk("ur_repeat_ones", ones, 16);
    chk("ur_sticky", int'(underrun), 1);
    ones = 0;
    run(64, 16'h2000, 1'b1, 1'b0);
    chk("w2000_ones", ones, 8);
    step(16'h2000, 1'b1, 1'b1);
    chk("ur_cleared", int'(underrun), 0);
    run(62, 16'h2000, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    chk("ur_set_wins", int'(underrun), 1);

    // valid mid-window with changing din: only the boundary value is taken
    for (int i = 0; i < 63; i++) step(16'(i * 1029 + 17), 1'b1, 1'b0);
    step(16'h1000, 1'b1, 1'b0);
    ones = 0;
    for (int i = 0; i < 63; i++) step(16'(16'hF000 - i * 977), 1'b1, 1'b0);
    step(16'hF000, 1'b1, 1'b0);
    chk("mid_window_ones", ones, 4);

    // reset mid-RUN with underrun set, then restart from acc=0
    run(5, 16'hF000, 1'b1, 1'b0);
    do_reset("midrun");
    step(16'h8000, 1'b1, 1'b0);
    ones = 0;
    run(1, 16'h8000, 1'b1, 1'b0);
    chk("restart_first", int'(dout), 0);
    run(1, 16'h8000, 1'b1, 1'b0);
    chk("restart_second", int'(dout), 1);
    run(62, 16'h8000, 1'b1, 1'b0);
    chk("restart_ones", ones, 32);

    // 0xFFFF from acc=0: first dout 0, 65535 ones in 65536 ticks
    do_reset("prefull");
    step(16'hFFFF, 1'b1, 1'b0);
    ones = 0;
    run(1, 16'hFFFF, 1'b1, 1'b0);
    chk("full_first", int'(dout), 0);
    run(65535, 16'hFFFF, 1'b1, 1'b0);
    chk("full_ones", ones, 65535);

    @(negedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dsm1_mod.md
# dsm1_mod

First-order delta-sigma modulator core. It accepts 16-bit unsigned PCM samples over a valid/ready handshake and holds each sample for OSR clock cycles. Every cycle it adds the held sample into a 16-bit phase accumulator, and the carry out of that addition becomes the 1-bit output stream. It sits directly downstream of the 16-bit adder datapath: it is the register, carry-capture and sample-sequencing stage that turns the combinational sum into a modulated bitstream for the output pin or the analog reconstruction filter.

## Interface
- OSR, 64, oversampling ratio: clock cycles each input sample is held; legal range 2..65535
- clk  input  1  modulator clock; every rising edge in RUN is one modulator tick
- rst  input  1  reset, asynchronous, active-high
- din  input  16  unsigned sample; output ones-density = din/65536
- din_valid  input  1  din is presented
- din_ready  output  1  block accepts din on this edge when din_valid=1
- dout  output  1  registered modulator bitstream
- underrun  output  1  sticky flag: no sample was available at a window boundary
- clr_underrun  input  1  synchronous clear of underrun

## Operation
- Internal registers:
  - state: IDLE or RUN.
  - x[15:0]: the held sample.
  - acc[15:0]: the accumulator.
  - cnt: window counter, ceil(log2(OSR)) bits.
- Reset (async, immediate, also when asserted mid-operation):
  - state=IDLE, acc=0, x=0, cnt=0, dout=0, underrun=0.
  - din_ready=1, because din_ready is decoded from state.
- IDLE:
  - din_ready=1, and acc and dout hold at 0.
  - On an edge with din_valid=1: x<=din, cnt<=0, state<=RUN. No accumulate happens on this edge.
- RUN, on every edge:
  - {dout,acc} <= {1'b0,acc} + {1'b0,x}, a 17-bit sum.
  - dout takes bit 16 (the carry) and acc takes bits 15:0, so acc wraps modulo 2^16.
  - cnt <= (cnt==OSR-1) ? 0 : cnt+1.
- din_ready in RUN: a combinational decode, 1 only while cnt==OSR-1, otherwise 0.
- Window boundary (RUN, cnt==OSR-1):
  - If din_valid=1: x<=din on this edge. The accumulate on this same edge still uses the old x; the new x is used from the next edge.
  - If din_valid=0: x is held (the last sample repeats for another window), underrun<=1, and the modulator keeps running.
- din_valid=1 outside the boundary cycle in RUN is ignored. Upstream must hold din/din_valid until din_ready.
- underrun:
  - Set only as described above.
  - clr_underrun=1 clears it on the next edge.
  - If set and clear occur on the same edge, set wins.
- RUN never returns to IDLE except via rst.
- Long-run density: for constant x starting from acc=0, exactly x ones appear in every 65536 consecutive ticks, with no drift.

## Timing
- Sample capture latency: dout reflects a newly captured sample from the 1st edge after capture.
- First RUN tick after IDLE capture: acc starts at 0, so the first dout is always 0 unless x=0xFFFF... that case also gives 0, because the carry of 0+x is 0 for any x.
- Handshake throughput: exactly one sample per OSR cycles; din_ready is high for 1 cycle per window.
- dout changes only on clk edges and is glitch-free; din_ready has a combinational path from the state/cnt registers only, with no path from din_valid.
- All state is updated on the rising edge of clk; no other clock domains.

## Test plan
- Reset, including an assertion mid-RUN: dout=0, din_ready=1 and underrun=0 immediately, without waiting for an edge. The state is IDLE, and the next din_valid restarts from acc=0.
- OSR=64, din=0x8000 held valid: dout reads 0,1,0,1,…; exactly 32 ones in each 64-cycle window; din_ready pulses once every 64 cycles.
- din=0x4000 constant: dout repeats 0,0,0,1 (16 ones per window). Then switch to 0x0000 at a boundary: all dout=0 from the edge after acceptance.
- din=0xFFFF constant: first dout=0, then 65535 ones over the first 65536 ticks; din=0x0001 gives a single 1 at tick 65536.
- Underrun:
  - Drop din_valid at one boundary: underrun=1 on the next cycle, and the previous x continues (pattern unbroken).
  - Supply the next sample at the following boundary: it is accepted normally, underrun stays 1, and clr_underrun=1 clears it.
  - Simultaneous underrun and clr_underrun: underrun=1.
- din_valid asserted mid-window with changing din: ignored until cnt==OSR-1. The captured value is the one present on the boundary edge, checked by counting ones over the next window.
